fx1_addx_pipe: RTL
==================

// Module: fx1_addx_pipe
// PURPOSE
//  Pipelined, parametrised extended-arithmetic unit for the FX1 pipe: ADDX, SFX, CGX and BGX
//  over NUM_SLOTS independent SLOT_W-bit slots of a 128-bit (default) register.
//  Carry/borrow-in per slot is the LSB of that slot of rt. Sits between FX1 operand fetch and
//  writeback. Uses a valid/ready handshake so writeback back-pressure stalls the unit.
// PARAMETERS
//  SLOT_W     32  bits per slot (>=2)
//  NUM_SLOTS  4   slots per operand; total width W = SLOT_W*NUM_SLOTS
//  STAGES     2   pipeline depth = latency in cycles (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   unit can accept a beat this cycle
//  op         in   2   fx1_pkg::addx_op_t: 0 ADDX, 1 SFX, 2 CGX, 3 BGX
//  ra         in   W   operand A, bit 0 = MSB ([0:W-1] numbering)
//  rb         in   W   operand B
//  rt         in   W   carry/borrow source; only the LSB of each slot is used
//  out_valid  out  1   result beat valid
//  out_ready  in   1   consumer accepts result
//  result     out  W   per-slot result
//  cout       out  NUM_SLOTS  per-slot carry-out (only with FX1_ADDX_FLAGS_EN); bit 0 = slot 0
// BEHAVIOUR
//  Per slot s (bits [s*SLOT_W : s*SLOT_W+SLOT_W-1]), c = rt[s*SLOT_W+SLOT_W-1]:
//   ADDX: {co,sum} = ra_s + rb_s + c;    result_s = sum
//   SFX : {co,sum} = rb_s + ~ra_s + c;   result_s = sum  (rb - ra - !c)
//   CGX : co as ADDX;  result_s = {SLOT_W-1 zeros, co}
//   BGX : co as SFX;   result_s = {SLOT_W-1 zeros, co}  (1 = no borrow)
//  Arithmetic is SLOT_W+1 bits wide; co is bit SLOT_W. The sum wraps modulo 2^SLOT_W.
//  No carry crosses slot boundaries.
//  Pipeline: global stall. adv = !out_valid || out_ready; in_ready = adv (combinational).
//   A beat is accepted when in_valid && in_ready. Its result appears exactly STAGES cycles
//   later if no stall occurs. Each stall cycle adds one cycle of latency.
//   Compute happens in stage 1; later stages are registers.
//   When !adv, every stage, including bubbles, holds its contents.
//   Accepting a new beat while the last stage is consumed in the same cycle is legal.
//   Full throughput is 1 beat/clk.
//  Output stays stable while out_valid && !out_ready. Beats are never dropped or duplicated.
//  Reset (async assert, sync deassert external): all stage valids=0, out_valid=0,
//   result=0, cout=0. in_ready=1 during and after reset. Reset mid-flight discards all beats.
//  Invalid stages carry don't-care data internally. result is 0 whenever out_valid=0
//   (data is gated at the output).
// CONFIGURATION
//  FX1_ADDX_FLAGS_EN defined: the cout port exists and is pipelined alongside result.
//   It carries co for every op, even ADDX/SFX.
//  FX1_ADDX_FLAGS_EN undefined: the cout port and its flops are absent; result is identical.
// STRUCTURE
//  fx1_pkg: addx_op_t enum (OP_ADDX, OP_SFX, OP_CGX, OP_BGX), default SLOT_W/NUM_SLOTS constants.
//  Sub-module fx1_addx_slot: one slot's combinational op/co logic (SLOT_W param).
//   It is instantiated NUM_SLOTS times by a generate loop.
//  Top level holds the stage register array, the valid chain and the handshake.
// TESTING
//  ADDX, slot0 ra=FFFFFFFF rb=0 rt lsb=1 -> slot0 result 00000000, cout[0]=1.
//   Other slots are independent, with no carry into slot 1.
//  SFX ra=5 rb=3 c=1 -> FFFFFFFE. BGX same operands -> 00000001? no: borrow -> 0.
//   BGX ra=3 rb=5 c=1 -> 00000001.
//  CGX ra=80000000 rb=80000000 c=0 -> 00000001. ADDX same operands -> 00000000.
//  Back-to-back beats with out_ready=1:
//   -> in-order results, one per cycle, first result STAGES cycles after the first accept.
//  Hold out_ready=0 for 5 cycles with the pipe full:
//   -> in_ready=0, result/out_valid stable, no loss or duplication on release.
//  Assert rst_n low mid-stream -> out_valid=0, result=0 immediately (async).
//   No stale beats after release. Run with and without FX1_ADDX_FLAGS_EN.

Source files
------------

// File: rtl/fx1_pkg.sv
// Shared types and default geometry for the FX1 extended-arithmetic pipe.
package fx1_pkg;

  typedef enum logic [1:0] {
    OP_ADDX = 2'd0,
    OP_SFX  = 2'd1,
    OP_CGX  = 2'd2,
    OP_BGX  = 2'd3
  } addx_op_t;

  localparam int FX1_SLOT_W    = 32;
  localparam int FX1_NUM_SLOTS = 4;

  function automatic logic op_is_add(input addx_op_t op);
    return (op == OP_ADDX) || (op == OP_CGX);
  endfunction

  function automatic logic op_is_flag(input addx_op_t op);
    return (op == OP_CGX) || (op == OP_BGX);
  endfunction

endpackage

// File: rtl/fx1_addx_slot.sv
// One slot of the FX1 extended-arithmetic unit: add/subtract with carry-in,
// returning either the wrapped sum or the carry-out as a one-bit result.
module fx1_addx_slot
  import fx1_pkg::*;
#(
  parameter int SLOT_W = FX1_SLOT_W
) (
  input  addx_op_t          op,
  input  logic [SLOT_W-1:0] a,
  input  logic [SLOT_W-1:0] b,
  input  logic              c,
  output logic [SLOT_W-1:0] res,
  output logic              co
);

  logic [SLOT_W:0] sum_w;
  logic [SLOT_W:0] cin_w;

  always_comb begin
    cin_w = {{SLOT_W{1'b0}}, c};
    // Subtract forms compute b + ~a + c, so co=1 means "no borrow".
    if (op_is_add(op)) begin
      sum_w = {1'b0, a} + {1'b0, b} + cin_w;
    end else begin
      sum_w = {1'b0, b} + {1'b0, ~a} + cin_w;
    end
    co = sum_w[SLOT_W];
    if (op_is_flag(op)) begin
      res = {{(SLOT_W-1){1'b0}}, sum_w[SLOT_W]};
    end else begin
      res = sum_w[SLOT_W-1:0];
    end
  end

endmodule

// File: rtl/fx1_addx_pipe.sv
// FX1 ADDX/SFX/CGX/BGX pipeline with global-stall valid/ready handshake.
// Define FX1_ADDX_FLAGS_EN to add the per-slot cout port and its pipeline flops.
module fx1_addx_pipe
  import fx1_pkg::*;
#(
  parameter int SLOT_W    = FX1_SLOT_W,
  parameter int NUM_SLOTS = FX1_NUM_SLOTS,
  parameter int STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  addx_op_t                      op,
  input  logic [0:SLOT_W*NUM_SLOTS-1]   ra,
  input  logic [0:SLOT_W*NUM_SLOTS-1]   rb,
  input  logic [0:SLOT_W*NUM_SLOTS-1]   rt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:SLOT_W*NUM_SLOTS-1]   result
`ifdef FX1_ADDX_FLAGS_EN
  ,
  output logic [NUM_SLOTS-1:0]          cout
`endif
);

  localparam int W = SLOT_W * NUM_SLOTS;

  logic [0:W-1]           res_c;
  logic [NUM_SLOTS-1:0]   co_c;
  logic                   adv;

  logic                   val_q [STAGES];
  logic                   val_d [STAGES];
  logic [0:W-1]           res_q [STAGES];
  logic [0:W-1]           res_d [STAGES];

  // Only the LSB of each rt slot feeds the datapath.
  logic unused_rt;
  assign unused_rt = ^rt;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    fx1_addx_slot #(.SLOT_W(SLOT_W)) u_slot (
      .op  (op),
      .a   (ra[s*SLOT_W +: SLOT_W]),
      .b   (rb[s*SLOT_W +: SLOT_W]),
      .c   (rt[s*SLOT_W+SLOT_W-1]),
      .res (res_c[s*SLOT_W +: SLOT_W]),
      .co  (co_c[s])
    );
  end

  assign adv      = !val_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      val_d[i] = val_q[i];
      res_d[i] = res_q[i];
    end
    if (adv) begin
      val_d[0] = in_valid;
      res_d[0] = res_c;
      for (int i = 1; i < STAGES; i++) begin
        val_d[i] = val_q[i-1];
        res_d[i] = res_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        val_q[i] <= 1'b0;
        res_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        val_q[i] <= val_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  // Data is gated so nothing stale is visible while the output is idle.
  assign out_valid = val_q[STAGES-1];
  assign result    = val_q[STAGES-1] ? res_q[STAGES-1] : '0;

`ifdef FX1_ADDX_FLAGS_EN
  logic [NUM_SLOTS-1:0] co_q [STAGES];
  logic [NUM_SLOTS-1:0] co_d [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      co_d[i] = co_q[i];
    end
    if (adv) begin
      co_d[0] = co_c;
      for (int i = 1; i < STAGES; i++) begin
        co_d[i] = co_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        co_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        co_q[i] <= co_d[i];
      end
    end
  end

  assign cout = val_q[STAGES-1] ? co_q[STAGES-1] : '0;
`else
  logic unused_co;
  assign unused_co = ^co_c;
`endif

endmodule
